use_output_arbiter: RTL and testbench

//  Round-robin scheduler for the shared output path of the stream-element array.

---
 rtl/use_output_arbiter.sv | 175 +++++++++++++++++
 tb/tb_use_output_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/use_output_arbiter.sv
// use_output_arbiter: round-robin grant over the stream-element array.
// The winning element's record is captured into a local buffer, acked once,
// and serialized onto a single AXI4-Stream master, one bus word per beat.
module use_output_arbiter #(
  parameter int NUM_ELEMENTS         = 4,
  parameter int MAX_USE_BYTES        = 38,
  parameter int DATA_BUS_WIDTH_BYTES = 8,
  parameter int LEN_WIDTH            = 6,
  parameter int CNT_WIDTH            = 16,
  localparam int TID_W               = $clog2(NUM_ELEMENTS)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_ELEMENTS-1:0]                     use_ready,
  input  logic [NUM_ELEMENTS*MAX_USE_BYTES*8-1:0]     use_data,
  input  logic [NUM_ELEMENTS*LEN_WIDTH-1:0]           use_len,
  output logic [NUM_ELEMENTS-1:0]                     use_ack,
  output logic [DATA_BUS_WIDTH_BYTES*8-1:0]           m_axis_tdata,
  output logic [DATA_BUS_WIDTH_BYTES-1:0]             m_axis_tkeep,
  output logic                                        m_axis_tlast,
  output logic [TID_W-1:0]                            m_axis_tid,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [CNT_WIDTH-1:0]                        rec_count,
  output logic                                        err_oversize
);

  localparam int DW        = DATA_BUS_WIDTH_BYTES;
  localparam int SLOT_W    = MAX_USE_BYTES * 8;
  localparam int BUS_W     = DW * 8;
  localparam int MAX_BEATS = (MAX_USE_BYTES + DW - 1) / DW;
  localparam int BUF_W     = MAX_BEATS * BUS_W;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DROP} state_t;

  state_t                  state_q;
  logic [NUM_ELEMENTS-1:0] ack_q;
  logic [TID_W-1:0]        rr_ptr_q;
  logic [TID_W-1:0]        tid_q;
  logic [BUF_W-1:0]        buf_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    tvalid_q;
  logic                    tlast_q;
  logic [BUS_W-1:0]        tdata_q;
  logic [DW-1:0]           tkeep_q;
  logic [CNT_WIDTH-1:0]    rec_count_q;
  logic                    err_q;

  // Per-element views of the flat input buses and per-beat views of the buffer.
  logic [SLOT_W-1:0]    slot_data [NUM_ELEMENTS];
  logic [LEN_WIDTH-1:0] slot_len  [NUM_ELEMENTS];
  logic [BUS_W-1:0]     beat_word [MAX_BEATS];

  generate
    for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_slot
      assign slot_data[gi] = use_data[gi*SLOT_W +: SLOT_W];
      assign slot_len[gi]  = use_len[gi*LEN_WIDTH +: LEN_WIDTH];
    end
    for (genvar gi = 0; gi < MAX_BEATS; gi++) begin : g_beat
      assign beat_word[gi] = buf_q[gi*BUS_W +: BUS_W];
    end
  endgenerate

  logic                 grant_found;
  logic [TID_W-1:0]     grant_idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 1; j <= NUM_ELEMENTS; j++) begin
      if (!grant_found && use_ready[(int'(rr_ptr_q) + j) % NUM_ELEMENTS]) begin
        grant_found = 1'b1;
        grant_idx   = TID_W'((int'(rr_ptr_q) + j) % NUM_ELEMENTS);
      end
    end
  end

  logic                 oversize;
  logic [LEN_WIDTH-1:0] grant_len;
  logic [DW-1:0]        first_keep;
  logic                 first_last;
  logic [BEAT_W-1:0]    next_beat;
  logic [BUS_W-1:0]     next_data;
  logic [DW-1:0]        next_keep;
  logic                 next_last;

  // Length clamp for the candidate, and keep/last for the first and the following beat.
  always_comb begin
    oversize   = slot_len[grant_idx] > LEN_WIDTH'(MAX_USE_BYTES);
    grant_len  = oversize ? LEN_WIDTH'(MAX_USE_BYTES) : slot_len[grant_idx];
    first_last = int'(grant_len) <= DW;
    next_beat  = beat_q + 1'b1;
    next_last  = (int'(next_beat) + 1) * DW >= int'(len_q);
    next_data  = (int'(next_beat) < MAX_BEATS) ? beat_word[next_beat] : '0;
    first_keep = '0;
    next_keep  = '0;
    for (int b = 0; b < DW; b++) begin
      first_keep[b] = b < int'(grant_len);
      next_keep[b]  = (int'(next_beat) * DW + b) < int'(len_q);
    end
  end

  // Grant / send / drop state machine; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ack_q       <= '0;
      rr_ptr_q    <= TID_W'(NUM_ELEMENTS - 1);
      tid_q       <= '0;
      buf_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      rec_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            buf_q    <= BUF_W'(slot_data[grant_idx]);
            len_q    <= grant_len;
            rr_ptr_q <= grant_idx;
            tid_q    <= grant_idx;
            beat_q   <= '0;
            ack_q    <= NUM_ELEMENTS'(1) << grant_idx;
            if (oversize) err_q <= 1'b1;
            if (grant_len == '0) begin
              state_q <= S_DROP;
            end else begin
              state_q  <= S_SEND;
              tvalid_q <= 1'b1;
              tdata_q  <= slot_data[grant_idx][BUS_W-1:0];
              tkeep_q  <= first_keep;
              tlast_q  <= first_last;
            end
          end
        end
        S_SEND: begin
          if (tvalid_q && m_axis_tready) begin
            if (tlast_q) begin
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
              rec_count_q <= rec_count_q + 1'b1;
              state_q     <= S_IDLE;
            end else begin
              beat_q  <= next_beat;
              tdata_q <= next_data;
              tkeep_q <= next_keep;
              tlast_q <= next_last;
            end
          end
        end
        S_DROP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign use_ack       = ack_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tvalid = tvalid_q;
  assign rec_count     = rec_count_q;
  assign err_oversize  = err_q;

endmodule

// File: tb/tb_use_output_arbiter.sv
// Testbench for use_output_arbiter: table of request scenarios plus
// hand-written latency and reset-mid-record sequences.
module tb_use_output_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 38;
  localparam int DW   = 8;
  localparam int LW   = 6;
  localparam int CW   = 16;
  localparam int IDW  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0]           use_ready;
  logic [N*MAXB*8-1:0]    use_data;
  logic [N*LW-1:0]        use_len;
  logic [N-1:0]           use_ack;
  logic [DW*8-1:0]        m_axis_tdata;
  logic [DW-1:0]          m_axis_tkeep;
  logic                   m_axis_tlast;
  logic [IDW-1:0]         m_axis_tid;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [CW-1:0]          rec_count;
  logic                   err_oversize;

  always #5 clk = ~clk;

  use_output_arbiter #(
    .NUM_ELEMENTS(N), .MAX_USE_BYTES(MAXB), .DATA_BUS_WIDTH_BYTES(DW),
    .LEN_WIDTH(LW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .use_ready(use_ready), .use_data(use_data),
    .use_len(use_len), .use_ack(use_ack), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .rec_count(rec_count), .err_oversize(err_oversize)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         tid;
    int         beats;
    logic [7:0] last_keep;
    int         data_err;
    int         keep_err;
  } rec_t;

  typedef struct {
    bit              do_reset;
    logic [3:0]      mask;
    int              len;
    bit              stall;
    int              nrec;
    logic [3:0][1:0] order;
    int              beats;
    logic [7:0]      keep;
    int              rec_cnt;
    bit              err;
    int              nack;
  } vec_t;

  rec_t recs[$];
  int   cur_beats, cur_de, cur_ke;
  int   ack_cnt;
  bit   stall_mode;
  int   phase;
  bit   held_valid;
  logic [75:0] held_bus;

  function automatic logic [7:0] pat(int e, int j);
    return 8'(e * 64 + j + 1);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle, negedge to negedge: drive tready, watch the beat/ack about
  // to be taken at the coming edge, then let acked elements drop ready.
  task automatic tick();
    logic [N-1:0] acks;
    acks = '0;
    m_axis_tready = stall_mode ? (phase % 3 == 0) : 1'b1;
    phase++;
    if (reset) begin
      cur_beats  = 0;
      cur_de     = 0;
      cur_ke     = 0;
      held_valid = 1'b0;
    end else begin
      if (held_valid)
        check("stall_hold", {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
              held_bus);
      held_valid = m_axis_tvalid && !m_axis_tready;
      held_bus   = {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        for (int b = 0; b < DW; b++)
          if (m_axis_tkeep[b] && m_axis_tdata[8*b +: 8] != pat(int'(m_axis_tid), DW*cur_beats + b))
            cur_de++;
        if (!m_axis_tlast && m_axis_tkeep != 8'hFF) cur_ke++;
        cur_beats++;
        if (m_axis_tlast) begin
          rec_t r;
          r.tid = int'(m_axis_tid);
          r.beats = cur_beats;
          r.last_keep = m_axis_tkeep;
          r.data_err = cur_de;
          r.keep_err = cur_ke;
          recs.push_back(r);
          $display("record tid=%0d beats=%0d last_keep=%02h", r.tid, r.beats, r.last_keep);
          cur_beats = 0;
          cur_de = 0;
          cur_ke = 0;
        end
      end
      acks = use_ack;
      ack_cnt += $countones(use_ack);
    end
    @(posedge clk);
    use_ready = use_ready & ~acks;
    @(negedge clk);
  endtask

  task automatic set_len(input int e, input int len);
    use_len[e*LW +: LW] = LW'(len);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      if (use_ready == '0 && !m_axis_tvalid) done = 1'b1;
    end
    check(name, done, 1'b1);
    tick();
    tick();
  endtask

  vec_t vecs[8];

  initial begin
    // scenario table: reset?, mask, len, stall, nrec, order, beats, last keep, rec_count, err, acks
    vecs[0] = '{1'b1, 4'b0010, 27, 1'b0, 1, 8'h01, 4, 8'h07, 1, 1'b0, 1};
    vecs[1] = '{1'b1, 4'b1111, 19, 1'b0, 4, 8'hE4, 3, 8'h07, 4, 1'b0, 4};
    vecs[2] = '{1'b1, 4'b0010, 27, 1'b1, 1, 8'h01, 4, 8'h07, 1, 1'b0, 1};
    vecs[3] = '{1'b0, 4'b1111,  8, 1'b0, 4, 8'h4E, 1, 8'hFF, 5, 1'b0, 4};
    vecs[4] = '{1'b0, 4'b0100,  0, 1'b0, 0, 8'h00, 0, 8'h00, 5, 1'b0, 1};
    vecs[5] = '{1'b0, 4'b1000, 45, 1'b0, 1, 8'h03, 5, 8'h3F, 6, 1'b1, 1};
    vecs[6] = '{1'b0, 4'b0001,  9, 1'b0, 1, 8'h00, 2, 8'h01, 7, 1'b1, 1};
    vecs[7] = '{1'b0, 4'b0011, 16, 1'b1, 2, 8'h01, 2, 8'hFF, 9, 1'b1, 2};

    reset = 1'b1;
    use_ready = '0;
    use_len = '0;
    use_data = '0;
    m_axis_tready = 1'b0;
    stall_mode = 1'b0;
    phase = 0;
    held_valid = 1'b0;
    held_bus = '0;
    cur_beats = 0; cur_de = 0; cur_ke = 0; ack_cnt = 0;
    for (int e = 0; e < N; e++)
      for (int j = 0; j < MAXB; j++)
        use_data[(e*MAXB + j)*8 +: 8] = pat(e, j);

    @(negedge clk);
    repeat (20) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tkeep", m_axis_tkeep, 8'h00);
    check("rst_tdata", m_axis_tdata, 64'h0);
    check("rst_tid", m_axis_tid, 2'd0);
    check("rst_ack", use_ack, 4'h0);
    check("rst_rec_count", rec_count, 16'd0);
    check("rst_err", err_oversize, 1'b0);

    // Latency: ready seen at one edge -> ack and first beat in the next cycle
    set_len(2, 5);
    use_ready = 4'b0100;
    tick();
    check("lat_ack", use_ack, 4'b0100);
    check("lat_tvalid", m_axis_tvalid, 1'b1);
    check("lat_tid", m_axis_tid, 2'd2);
    check("lat_tkeep", m_axis_tkeep, 8'h1F);
    check("lat_tlast", m_axis_tlast, 1'b1);
    tick();
    check("lat_ack_clear", use_ack, 4'b0000);
    check("lat_tvalid_clear", m_axis_tvalid, 1'b0);
    check("lat_rec_count", rec_count, 16'd1);
    $display("latency sequence done");

    // Table-driven scenarios
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].do_reset) begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
      end
      recs.delete();
      ack_cnt = 0;
      stall_mode = vecs[v].stall;
      phase = 0;
      for (int e = 0; e < N; e++)
        if (vecs[v].mask[e]) set_len(e, vecs[v].len);
      use_ready = vecs[v].mask;
      drain("vec_drain");
      check("vec_nrec", recs.size(), vecs[v].nrec);
      for (int i = 0; i < vecs[v].nrec; i++) begin
        if (i < recs.size()) begin
          check("vec_tid", recs[i].tid, int'(vecs[v].order[i]));
          check("vec_beats", recs[i].beats, vecs[v].beats);
          check("vec_last_keep", recs[i].last_keep, vecs[v].keep);
          check("vec_data", recs[i].data_err, 0);
          check("vec_mid_keep", recs[i].keep_err, 0);
        end
      end
      check("vec_acks", ack_cnt, vecs[v].nack);
      check("vec_rec_count", rec_count, vecs[v].rec_cnt);
      check("vec_err", err_oversize, vecs[v].err);
      $display("vector %0d mask=%b len=%0d stall=%0d records=%0d acks=%0d rec_count=%0d",
               v, vecs[v].mask, vecs[v].len, vecs[v].stall, recs.size(), ack_cnt, rec_count);
      stall_mode = 1'b0;
    end

    // Reset during beat 2 of a 33-byte record from element 0
    begin
      bit at_beat2;
      at_beat2 = 1'b0;
      recs.delete();
      set_len(0, 33);
      use_ready = 4'b0001;
      for (int c = 0; c < 50 && !at_beat2; c++) begin
        tick();
        if (cur_beats == 1 && m_axis_tvalid) at_beat2 = 1'b1;
      end
      check("mid_reach_beat2", at_beat2, 1'b1);
      reset = 1'b1;
      tick();
      check("mid_tvalid", m_axis_tvalid, 1'b0);
      check("mid_tlast", m_axis_tlast, 1'b0);
      check("mid_tkeep", m_axis_tkeep, 8'h00);
      check("mid_tdata", m_axis_tdata, 64'h0);
      check("mid_rec_count", rec_count, 16'd0);
      check("mid_err", err_oversize, 1'b0);
      check("mid_no_tlast", recs.size(), 0);
      reset = 1'b0;
      tick();
      set_len(0, 8);
      set_len(1, 8);
      use_ready = 4'b0011;
      drain("mid_drain");
      check("mid_nrec", recs.size(), 2);
      if (recs.size() > 0) check("mid_first_tid", recs[0].tid, 0);
      if (recs.size() > 1) check("mid_second_tid", recs[1].tid, 1);
      check("mid_rec_count_after", rec_count, 16'd2);
      $display("reset-mid-record sequence done records=%0d", recs.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
